// File: rtl/nubus_pkg.sv
// Shared encodings for the NuBus card memory arbiter and related master-path blocks.
package nubus_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_S = 2'd1;
  localparam logic [1:0] ST_GRANT_L = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  localparam logic OWN_S = 1'b0;
  localparam logic OWN_L = 1'b1;

  // Wide enough for any supported data width; users slice the low DW bits.
  localparam logic [127:0] NUBUS_ERR_DATA = '1;

endpackage

// File: rtl/nubus_mem_arbiter_wdog.sv
// Watchdog counter: clear has priority, counts while enabled, expire flags the TIMEOUT-th enabled cycle.
module nubus_arb_wdog
  import nubus_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign expire = en && (cnt_q == 16'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/nubus_mem_arbiter.sv
// Shares the card memory port between the NuBus slave path (S) and the local master (L).
// One access in flight; S preferred, L forced through after STARVE_MAX S wins; stalled accesses time out.
module nubus_mem_arbiter
  import nubus_pkg::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_valid,
  input  logic          s_write,
  input  logic [AW-1:0] s_addr,
  input  logic [DW-1:0] s_wdata,
  output logic          s_ready,
  output logic [DW-1:0] s_rdata,
  output logic          s_err,
  input  logic          l_valid,
  input  logic          l_write,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ready,
  output logic [DW-1:0] l_rdata,
  output logic          l_err,
  output logic          m_valid,
  output logic          m_write,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic          m_ready,
  input  logic [DW-1:0] m_rdata,
  output logic          busy_o,
  output logic          timeout_o
);

  localparam logic [DW-1:0] ERR_DATA = NUBUS_ERR_DATA[DW-1:0];
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0]    state_q, state_d;
  logic [3:0]    starve_q, starve_d;
  logic          m_valid_q, m_valid_d, m_write_q, m_write_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          s_ready_q, s_ready_d, s_err_q, s_err_d;
  logic          l_ready_q, l_ready_d, l_err_q, l_err_d;
  logic [DW-1:0] s_rdata_q, s_rdata_d, l_rdata_q, l_rdata_d;
  logic          timeout_q, timeout_d;

  logic in_grant, grant_entry, pick, expire;

  assign in_grant    = (state_q == ST_GRANT_S) || (state_q == ST_GRANT_L);
  assign grant_entry = (state_q == ST_IDLE) && (s_valid || l_valid);
  assign pick        = (l_valid && (!s_valid || (starve_q == STARVE_LIM))) ? OWN_L : OWN_S;

  nubus_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (grant_entry),
    .en     (in_grant),
    .expire (expire)
  );

  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    m_valid_d = m_valid_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    s_ready_d = 1'b0;
    s_err_d   = 1'b0;
    s_rdata_d = s_rdata_q;
    l_ready_d = 1'b0;
    l_err_d   = 1'b0;
    l_rdata_d = l_rdata_q;
    timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!l_valid) starve_d = '0;
        if (grant_entry) begin
          m_valid_d = 1'b1;
          m_write_d = (pick == OWN_L) ? l_write : s_write;
          m_addr_d  = (pick == OWN_L) ? l_addr  : s_addr;
          m_wdata_d = (pick == OWN_L) ? l_wdata : s_wdata;
          if (pick == OWN_L) begin
            state_d  = ST_GRANT_L;
            starve_d = '0;
          end else begin
            state_d = ST_GRANT_S;
            if (l_valid && (starve_q != STARVE_LIM)) starve_d = starve_q + 4'd1;
          end
        end
      end
      ST_GRANT_S, ST_GRANT_L: begin
        // A completion arriving on the expiry cycle is a normal completion.
        if (m_ready || expire) begin
          m_valid_d = 1'b0;
          state_d   = ST_RELEASE;
          timeout_d = !m_ready;
          if (state_q == ST_GRANT_L) begin
            l_ready_d = 1'b1;
            l_err_d   = !m_ready;
            l_rdata_d = m_ready ? m_rdata : ERR_DATA;
          end else begin
            s_ready_d = 1'b1;
            s_err_d   = !m_ready;
            s_rdata_d = m_ready ? m_rdata : ERR_DATA;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      starve_q  <= '0;
      m_valid_q <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      s_ready_q <= 1'b0;
      s_err_q   <= 1'b0;
      s_rdata_q <= '0;
      l_ready_q <= 1'b0;
      l_err_q   <= 1'b0;
      l_rdata_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      m_valid_q <= m_valid_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      s_ready_q <= s_ready_d;
      s_err_q   <= s_err_d;
      s_rdata_q <= s_rdata_d;
      l_ready_q <= l_ready_d;
      l_err_q   <= l_err_d;
      l_rdata_q <= l_rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_write   = m_write_q;
  assign m_addr    = m_addr_q;
  assign m_wdata   = m_wdata_q;
  assign s_ready   = s_ready_q;
  assign s_err     = s_err_q;
  assign s_rdata   = s_rdata_q;
  assign l_ready   = l_ready_q;
  assign l_err     = l_err_q;
  assign l_rdata   = l_rdata_q;
  assign timeout_o = timeout_q;
  assign busy_o    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Bench for nubus_mem_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_nubus_mem_arbiter;

  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 0, s_write = 0, l_valid = 0, l_write = 0, m_ready = 0;
  logic [31:0] s_addr = 0, s_wdata = 0, l_addr = 0, l_wdata = 0, m_rdata = 0;
  logic        s_ready, s_err, l_ready, l_err, m_valid, m_write, busy_o, timeout_o;
  logic [31:0] s_rdata, l_rdata, m_addr, m_wdata;

  int checks = 0;
  int fails  = 0;

  nubus_mem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_write(s_write), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_ready(s_ready), .s_rdata(s_rdata), .s_err(s_err),
    .l_valid(l_valid), .l_write(l_write), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_ready(l_ready), .l_rdata(l_rdata), .l_err(l_err),
    .m_valid(m_valid), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] ctl;
    ctl = {s_ready, s_err, l_ready, l_err, m_valid, busy_o, timeout_o};
    checks++;
    if (ctl !== 7'd0) begin fails++; $display("FAIL reset_ctl: got %b want 0000000", ctl); end
    checks++;
    if ({s_rdata, l_rdata, m_addr, m_wdata, m_write} !== '0) begin
      fails++; $display("FAIL reset_data: got %h %h %h %h want all zero", s_rdata, l_rdata, m_addr, m_wdata);
    end
    @(negedge clk); reset = 1'b0;
    tick();
  endtask

  task automatic test_s_read();
    s_valid = 1; s_write = 0; s_addr = 32'h100;
    tick();
    checks++;
    if ({m_valid, busy_o, m_write, m_addr} !== {1'b1, 1'b1, 1'b0, 32'h100}) begin
      fails++; $display("FAIL s_read_req: got v=%b busy=%b w=%b a=%h want v=1 busy=1 w=0 a=100", m_valid, busy_o, m_write, m_addr);
    end
    m_ready = 1; m_rdata = 32'hDEADBEEF;
    tick();
    m_ready = 0; m_rdata = 32'h0;
    checks++;
    if ({s_ready, s_err, l_ready, m_valid, busy_o} !== 5'b10001) begin
      fails++; $display("FAIL s_read_ack: got rdy=%b err=%b lrdy=%b mv=%b busy=%b want 1 0 0 0 1", s_ready, s_err, l_ready, m_valid, busy_o);
    end
    checks++;
    if (s_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL s_read_data: got %h want deadbeef", s_rdata); end
    s_valid = 0;
    tick();
    checks++;
    if ({s_ready, busy_o, m_valid} !== 3'b000 || s_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL s_read_release: got rdy=%b busy=%b mv=%b rdata=%h want 0 0 0 deadbeef", s_ready, busy_o, m_valid, s_rdata);
    end
  endtask

  task automatic test_simultaneous();
    s_valid = 1; s_write = 0; s_addr = 32'h140;
    l_valid = 1; l_write = 1; l_addr = 32'h200; l_wdata = 32'hCAFEF00D;
    tick();
    checks++;
    if ({m_valid, m_addr} !== {1'b1, 32'h140}) begin
      fails++; $display("FAIL simul_first: got v=%b a=%h want v=1 a=140", m_valid, m_addr);
    end
    m_ready = 1; m_rdata = 32'h11112222;
    tick();
    m_ready = 0;
    checks++;
    if ({s_ready, l_ready} !== 2'b10) begin fails++; $display("FAIL simul_s_ack: got s=%b l=%b want 1 0", s_ready, l_ready); end
    s_valid = 0;
    tick(); tick();
    checks++;
    if ({m_valid, m_write, m_addr, m_wdata} !== {1'b1, 1'b1, 32'h200, 32'hCAFEF00D}) begin
      fails++; $display("FAIL simul_l_req: got v=%b w=%b a=%h d=%h want 1 1 200 cafef00d", m_valid, m_write, m_addr, m_wdata);
    end
    m_ready = 1;
    tick();
    m_ready = 0;
    checks++;
    if ({s_ready, l_ready, l_err} !== 3'b010) begin
      fails++; $display("FAIL simul_l_ack: got s=%b l=%b lerr=%b want 0 1 0", s_ready, l_ready, l_err);
    end
    l_valid = 0; l_write = 0;
    tick();
  endtask

  task automatic test_starvation();
    int n;
    logic own_l, exp_l;
    s_valid = 1; s_addr = 32'h1000; l_valid = 1; l_addr = 32'h2000;
    for (int g = 0; g < 2 * (STARVE_MAX + 1); g++) begin
      n = 0;
      do begin tick(); n++; end while (!m_valid && n < 20);
      checks++;
      if (!m_valid) begin fails++; $display("FAIL starve_wait: got no grant want grant %0d", g); break; end
      own_l = (m_addr == 32'h2000);
      exp_l = ((g % (STARVE_MAX + 1)) == STARVE_MAX);
      checks++;
      if (own_l !== exp_l) begin fails++; $display("FAIL starve_owner: grant %0d got L=%b want L=%b", g, own_l, exp_l); end
      m_ready = 1; m_rdata = g;
      tick();
      m_ready = 0;
    end
    s_valid = 0; l_valid = 0;
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n;
    l_valid = 1; l_write = 0; l_addr = 32'h300;
    tick();
    n = 0;
    while (m_valid && n < 20) begin n++; tick(); end
    checks++;
    if (n != TIMEOUT) begin fails++; $display("FAIL timeout_len: got %0d cycles want %0d", n, TIMEOUT); end
    checks++;
    if ({l_ready, l_err, timeout_o, s_ready, m_valid} !== 5'b11100 || l_rdata !== 32'hFFFFFFFF) begin
      fails++; $display("FAIL timeout_resp: got rdy=%b err=%b to=%b srdy=%b mv=%b rdata=%h want 1 1 1 0 0 ffffffff",
                        l_ready, l_err, timeout_o, s_ready, m_valid, l_rdata);
    end
    l_valid = 0;
    tick();
    checks++;
    if ({l_ready, l_err, timeout_o} !== 3'b000) begin
      fails++; $display("FAIL timeout_pulse: got rdy=%b err=%b to=%b want 0 0 0", l_ready, l_err, timeout_o);
    end
    l_valid = 1; l_addr = 32'h304;
    tick();
    n = 0;
    while (m_valid && n < 20) begin
      n++;
      if (n == TIMEOUT) begin m_ready = 1; m_rdata = 32'h12345678; end
      tick();
      m_ready = 0;
    end
    checks++;
    if ({l_ready, l_err, timeout_o} !== 3'b100 || l_rdata !== 32'h12345678) begin
      fails++; $display("FAIL timeout_race: got rdy=%b err=%b to=%b rdata=%h want 1 0 0 12345678", l_ready, l_err, timeout_o, l_rdata);
    end
    l_valid = 0;
    tick();
  endtask

  task automatic test_ack_lag();
    logic regrant;
    s_valid = 1; s_addr = 32'h500;
    tick();
    m_ready = 1; m_rdata = 32'h55;
    tick();
    m_ready = 0;
    checks++;
    if (s_ready !== 1'b1) begin fails++; $display("FAIL lag_ack: got %b want 1", s_ready); end
    tick();
    s_valid = 0;
    checks++;
    if ({m_valid, busy_o} !== 2'b00) begin fails++; $display("FAIL lag_release: got mv=%b busy=%b want 0 0", m_valid, busy_o); end
    regrant = 0;
    for (int i = 0; i < 4; i++) begin tick(); regrant |= m_valid; end
    checks++;
    if (regrant !== 1'b0) begin fails++; $display("FAIL lag_regrant: got %b want 0", regrant); end
  endtask

  task automatic test_async_reset();
    logic bad;
    s_valid = 1; s_addr = 32'h600;
    tick();
    #2;
    reset = 1; s_valid = 0;
    #1;
    checks++;
    if ({m_valid, busy_o, s_ready} !== 3'b000) begin
      fails++; $display("FAIL areset_now: got mv=%b busy=%b srdy=%b want 0 0 0", m_valid, busy_o, s_ready);
    end
    tick(); tick();
    @(negedge clk); reset = 0;
    m_ready = 1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin tick(); bad |= s_ready | m_valid; end
    m_ready = 0;
    checks++;
    if (bad !== 1'b0) begin fails++; $display("FAIL areset_ghost: got %b want 0", bad); end
  endtask

  task automatic test_random();
    logic prev_s = 0, prev_l = 0, s_pend = 0, l_pend = 0, s_ack, l_ack;
    logic exp_cmp = 0, exp_err = 0, cur_own = 0, eo;
    logic [31:0] exp_dat = 0, got_d;
    logic [5:0] got6, want6;
    int consec = 0, gcnt = 0, lat = 0, s_wait = 0, l_wait = 0;
    for (int c = 0; c < 1500; c++) begin
      tick();
      got6 = {s_ready, s_err, l_ready, l_err, timeout_o, m_valid};
      if (exp_cmp) begin
        want6 = cur_own ? {2'b00, 1'b1, exp_err, exp_err, 1'b0} : {1'b1, exp_err, 2'b00, exp_err, 1'b0};
        checks++;
        if (got6 !== want6) begin fails++; $display("FAIL rnd_resp c=%0d: got %b want %b", c, got6, want6); end
        got_d = cur_own ? l_rdata : s_rdata;
        checks++;
        if (got_d !== exp_dat) begin fails++; $display("FAIL rnd_rdata c=%0d: got %h want %h", c, got_d, exp_dat); end
        exp_cmp = 0;
      end else begin
        checks++;
        if ({s_ready, l_ready, timeout_o} !== 3'b000) begin
          fails++; $display("FAIL rnd_spurious c=%0d: got srdy=%b lrdy=%b to=%b want 0 0 0", c, s_ready, l_ready, timeout_o);
        end
      end
      m_ready = 0;
      if (m_valid) begin
        if (gcnt == 0) begin
          eo = (prev_s && prev_l) ? (consec == STARVE_MAX) : prev_l;
          if (eo) consec = 0;
          else if (prev_l && consec < STARVE_MAX) consec++;
          cur_own = eo;
          checks++;
          if (eo ? ({m_write, m_addr, m_wdata} !== {l_write, l_addr, l_wdata}) || !prev_l
                 : ({m_write, m_addr, m_wdata} !== {s_write, s_addr, s_wdata}) || !prev_s) begin
            fails++; $display("FAIL rnd_grant c=%0d: got w=%b a=%h d=%h want owner L=%b", c, m_write, m_addr, m_wdata, eo);
          end
          lat = ($urandom_range(0, 7) == 0) ? 99 : $urandom_range(1, 4);
        end
        gcnt++;
        if (gcnt == lat) begin
          m_ready = 1; m_rdata = $urandom; exp_dat = m_rdata; exp_err = 0; exp_cmp = 1; gcnt = 0;
        end else if (gcnt == TIMEOUT) begin
          exp_dat = 32'hFFFFFFFF; exp_err = 1; exp_cmp = 1; gcnt = 0;
        end
      end
      s_ack = s_pend && s_ready;
      l_ack = l_pend && l_ready;
      if (s_ack) begin s_pend = 0; s_valid = 0; s_wait = 0; end
      if (l_ack) begin l_pend = 0; l_valid = 0; l_wait = 0; end
      if (s_pend) s_wait++;
      if (l_pend) l_wait++;
      if (s_wait > 100 || l_wait > 100) begin
        checks++; fails++; $display("FAIL rnd_stall c=%0d: got waits %0d/%0d want completion", c, s_wait, l_wait);
        break;
      end
      if (!s_pend && !s_ack && $urandom_range(0, 3) != 0) begin
        s_pend = 1; s_valid = 1; s_write = 1'($urandom); s_addr = $urandom; s_wdata = $urandom;
      end
      if (!l_pend && !l_ack && $urandom_range(0, 2) == 0) begin
        l_pend = 1; l_valid = 1; l_write = 1'($urandom); l_addr = $urandom; l_wdata = $urandom;
      end
      prev_s = s_valid;
      prev_l = l_valid;
    end
    s_valid = 0; l_valid = 0; m_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    #3;
    test_reset();
    test_s_read();
    test_simultaneous();
    test_starvation();
    test_timeout();
    test_ack_lag();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
